// File: rtl/sipo_pkg.sv
// Shared definitions for the framed serial-to-parallel receiver.
package sipo_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DATA      = 2'd1,
        STOP      = 2'd2,
        WAIT_HIGH = 2'd3
    } state_e;

    localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/sipo_shift.sv
// WIDTH-bit right-shift register: new bits enter at the MSB, so the first
// bit shifted in ends up in bit 0 after WIDTH shifts.
module sipo_shift
    import sipo_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en,
    input  logic             serial_in,
    output logic [WIDTH-1:0] data
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Shift one line sample in from the top when enabled, otherwise hold.
    always_comb begin
        data_d = data_q;
        if (shift_en) begin
            data_d = {serial_in, data_q[WIDTH-1:1]};
        end
    end

    // Shift register storage, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data = data_q;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Framed receiver controller: hunts for a start bit, collects WIDTH data bits
// LSB first, checks the stop bit and offers the word on a valid/ready port.
module sipo_frame_ctrl
    import sipo_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             bit_en,
    input  logic             serial_in,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_err,
    output logic             overrun,
    input  logic             clr_overrun,
    output logic             busy
);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0] out_data_q;
    logic [WIDTH-1:0] out_data_d;
    logic             out_valid_q;
    logic             out_valid_d;
    logic             frame_err_q;
    logic             frame_err_d;
    logic             overrun_q;
    logic             overrun_d;

    logic             shift_en;
    logic [WIDTH-1:0] shift_data;
    logic             frame_good;
    logic             frame_bad;
    logic             overrun_set;

    assign shift_en = (state_q == DATA) && bit_en;

    sipo_shift #(
        .WIDTH(WIDTH)
    ) u_shift (
        .clk      (clk),
        .reset    (reset),
        .shift_en (shift_en),
        .serial_in(serial_in),
        .data     (shift_data)
    );

    // Frame sequencing: every move is gated by the bit strobe, except that
    // dropping enable abandons the frame immediately.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        frame_good = 1'b0;
        frame_bad  = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (bit_en) begin
            case (state_q)
                IDLE: begin
                    if (serial_in != LINE_IDLE) begin
                        cnt_d   = '0;
                        state_d = DATA;
                    end
                end
                DATA: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = STOP;
                    end
                end
                STOP: begin
                    if (serial_in == LINE_IDLE) begin
                        frame_good = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        frame_bad = 1'b1;
                        state_d   = WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    if (serial_in == LINE_IDLE) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Output port: a finished word loads when the slot is free or being
    // emptied this very cycle; otherwise it is dropped and flagged.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;
        overrun_set = 1'b0;
        frame_err_d = frame_bad;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (frame_good) begin
            if (!out_valid_q || out_ready) begin
                out_data_d  = shift_data;
                out_valid_d = 1'b1;
            end else begin
                overrun_set = 1'b1;
            end
        end
        if (clr_overrun) begin
            overrun_d = 1'b0;
        end
        if (overrun_set) begin
            overrun_d = 1'b1;
        end
    end

    // Controller and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Bench for sipo_frame_ctrl: directed frames with literal expectations plus a
// randomized line, all compared every cycle against a queue-based frame model.
module tb_sipo_frame_ctrl;

    localparam int WIDTH = 4;
    localparam int CNT_W = 4;

    logic             clk         = 1'b0;
    logic             reset       = 1'b0;
    logic             enable      = 1'b0;
    logic             bit_en      = 1'b0;
    logic             serial_in   = 1'b1;
    logic             out_ready   = 1'b0;
    logic             clr_overrun = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             frame_err;
    logic             overrun;
    logic             busy;

    int n_vectors     = 0;
    int n_miscompares = 0;

    // Reference model state: a receive queue of data bits plus two flags.
    bit               m_in_frame   = 1'b0;
    bit               m_await_high = 1'b0;
    bit               m_bits[$];
    logic [WIDTH-1:0] m_data  = '0;
    logic             m_valid = 1'b0;
    logic             m_ferr  = 1'b0;
    logic             m_ovr   = 1'b0;

    sipo_frame_ctrl #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .bit_en     (bit_en),
        .serial_in  (serial_in),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .clr_overrun(clr_overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic void modelReset();
        m_in_frame   = 1'b0;
        m_await_high = 1'b0;
        m_bits.delete();
        m_data  = '0;
        m_valid = 1'b0;
        m_ferr  = 1'b0;
        m_ovr   = 1'b0;
    endfunction

    function automatic logic [WIDTH-1:0] packWord();
        logic [WIDTH-1:0] w = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w[i] = m_bits[i];
        end
        return w;
    endfunction

    function automatic void modelStep(input logic en, input logic be, input logic ser,
                                      input logic rdy, input logic clr);
        bit               deliver = 1'b0;
        bit               drop    = 1'b0;
        logic [WIDTH-1:0] word    = '0;
        m_ferr = 1'b0;
        if (!en) begin
            m_in_frame   = 1'b0;
            m_await_high = 1'b0;
            m_bits.delete();
        end else if (be) begin
            if (m_await_high) begin
                if (ser) m_await_high = 1'b0;
            end else if (!m_in_frame) begin
                if (!ser) begin
                    m_in_frame = 1'b1;
                    m_bits.delete();
                end
            end else if (m_bits.size() < WIDTH) begin
                m_bits.push_back(ser);
            end else begin
                m_in_frame = 1'b0;
                if (ser) begin
                    deliver = 1'b1;
                    word    = packWord();
                end else begin
                    m_ferr       = 1'b1;
                    m_await_high = 1'b1;
                end
            end
        end
        if (deliver && (!m_valid || rdy)) begin
            m_data  = word;
            m_valid = 1'b1;
        end else begin
            if (deliver) drop = 1'b1;
            if (m_valid && rdy) m_valid = 1'b0;
        end
        if (drop) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
    endfunction

    // Advance the model on each edge and compare the registered outputs just after it.
    always @(posedge clk) begin
        if (!reset) modelReset();
        else modelStep(enable, bit_en, serial_in, out_ready, clr_overrun);
        #1;
        checkOutput("cmp_out_valid", 16'(out_valid), 16'(m_valid));
        checkOutput("cmp_out_data", 16'(out_data), 16'(m_data));
        checkOutput("cmp_frame_err", 16'(frame_err), 16'(m_ferr));
        checkOutput("cmp_overrun", 16'(overrun), 16'(m_ovr));
        checkOutput("cmp_busy", 16'(busy), 16'(m_in_frame || m_await_high));
    end

    // The model follows the asynchronous reset as soon as it is asserted.
    always @(negedge reset) modelReset();

    task automatic applyStimulus(input logic en, input logic be, input logic ser,
                                 input logic rdy, input logic clr);
        enable      = en;
        bit_en      = be;
        serial_in   = ser;
        out_ready   = rdy;
        clr_overrun = clr;
        @(negedge clk);
    endtask

    task automatic sendFrame(input logic [WIDTH-1:0] word, input logic stop, input logic rdy_on_stop);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < WIDTH; i++) begin
            applyStimulus(1'b1, 1'b1, word[i], 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 1'b1, stop, rdy_on_stop, 1'b0);
    endtask

    initial begin
        bit   plan[$];
        logic be;
        logic ser;
        logic [WIDTH-1:0] w;
        bit   seq[$];

        // Reset state.
        #2;
        checkOutput("rst_out_valid", 16'(out_valid), 16'h0);
        checkOutput("rst_out_data", 16'(out_data), 16'h0);
        checkOutput("rst_busy", 16'(busy), 16'h0);
        checkOutput("rst_overrun", 16'(overrun), 16'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        // Good frame 0xD.
        sendFrame(4'hD, 1'b1, 1'b0);
        checkOutput("good_valid", 16'(out_valid), 16'h1);
        checkOutput("good_data", 16'(out_data), 16'hD);
        checkOutput("good_ferr", 16'(frame_err), 16'h0);
        checkOutput("good_busy", 16'(busy), 16'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("drain_valid", 16'(out_valid), 16'h0);
        checkOutput("drain_data_held", 16'(out_data), 16'hD);

        // Framing error followed by a held-low line.
        sendFrame(4'h6, 1'b0, 1'b0);
        checkOutput("ferr_pulse", 16'(frame_err), 16'h1);
        checkOutput("ferr_valid", 16'(out_valid), 16'h0);
        checkOutput("ferr_busy", 16'(busy), 16'h1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            checkOutput("break_no_ferr", 16'(frame_err), 16'h0);
            checkOutput("break_busy", 16'(busy), 16'h1);
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("break_release_busy", 16'(busy), 16'h0);

        // Overrun and its clear.
        sendFrame(4'hA, 1'b1, 1'b0);
        sendFrame(4'h5, 1'b1, 1'b0);
        checkOutput("ovr_data_kept", 16'(out_data), 16'hA);
        checkOutput("ovr_flag", 16'(overrun), 16'h1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("ovr_cleared", 16'(overrun), 16'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

        // Back-to-back words with accept on the second stop bit.
        sendFrame(4'h6, 1'b1, 1'b0);
        checkOutput("b2b_first", 16'(out_data), 16'h6);
        sendFrame(4'h9, 1'b1, 1'b1);
        checkOutput("b2b_valid", 16'(out_valid), 16'h1);
        checkOutput("b2b_second", 16'(out_data), 16'h9);
        checkOutput("b2b_no_ovr", 16'(overrun), 16'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

        // Abort by enable, then a clean frame.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("abort_busy", 16'(busy), 16'h0);
        checkOutput("abort_valid", 16'(out_valid), 16'h0);
        sendFrame(4'h3, 1'b1, 1'b0);
        checkOutput("after_abort_data", 16'(out_data), 16'h3);
        checkOutput("after_abort_valid", 16'(out_valid), 16'h1);

        // Asynchronous reset in the middle of a frame.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        checkOutput("arst_valid", 16'(out_valid), 16'h0);
        checkOutput("arst_data", 16'(out_data), 16'h0);
        checkOutput("arst_busy", 16'(busy), 16'h0);
        checkOutput("arst_ferr", 16'(frame_err), 16'h0);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        // Sparse strobe: line toggles between samples, word 0xB.
        seq = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        foreach (seq[k]) begin
            applyStimulus(1'b1, 1'b0, ~seq[k], 1'b0, 1'b0);
            applyStimulus(1'b1, 1'b0, ~seq[k], 1'b0, 1'b0);
            applyStimulus(1'b1, 1'b1, seq[k], 1'b0, 1'b0);
        end
        checkOutput("gated_valid", 16'(out_valid), 16'h1);
        checkOutput("gated_data", 16'(out_data), 16'hB);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

        // Randomized line built from planned frames with noise between strobes.
        for (int c = 0; c < 3000; c++) begin
            be = (c < 1500) ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (be) begin
                if (plan.size() == 0) begin
                    w = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
                    for (int j = 0; j < $urandom_range(0, 2); j++) plan.push_back(1'b1);
                    plan.push_back(1'b0);
                    for (int j = 0; j < WIDTH; j++) plan.push_back(w[j]);
                    plan.push_back($urandom_range(0, 9) != 0);
                end
                ser = plan.pop_front();
            end else begin
                ser = 1'($urandom_range(0, 1));
            end
            applyStimulus($urandom_range(0, 199) != 0, be, ser,
                          $urandom_range(0, 3) == 0, $urandom_range(0, 49) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
